teletext_frontend: RTL and testbench



---
 rtl/teletext_frontend.sv | 142 ++++++++++++++
 tb/tb_teletext_frontend.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/teletext_frontend.sv
// teletext_frontend: character-rate timing generator and pixel-word serialiser for the teletext core.
// Define TELETEXT_FRONTEND_PO_BLANK_EN to add the po input and blan output for picture-on blanking.
module teletext_frontend #(
  parameter int PIXELS_PER_CHAR   = 12,
  parameter int TICKS_PER_CHAR    = 2,
  parameter int SCANLINES_PER_ROW = 10,
  parameter int ROWS_PER_FRAME    = 25,
  parameter int FLASH_FRAMES      = 16,
  localparam int PPT = PIXELS_PER_CHAR / TICKS_PER_CHAR,
  localparam int SW  = $clog2(SCANLINES_PER_ROW),
  localparam int RW  = $clog2(ROWS_PER_FRAME)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       char_enable,
  input  logic                       lose,
  input  logic                       glr,
  input  logic                       dew,
  input  logic                       crs,
  input  logic [6:0]                 data_in,
`ifdef TELETEXT_FRONTEND_PO_BLANK_EN
  input  logic                       po,
  output logic                       blan,
`endif
  output logic                       tt_character__valid,
  output logic [6:0]                 tt_character__character,
  output logic                       tt_timings__restart_frame,
  output logic                       tt_timings__end_of_scanline,
  output logic                       tt_timings__first_scanline_of_row,
  output logic                       tt_timings__smoothe,
  output logic [1:0]                 tt_timings__interpolate_vertical,
  input  logic                       tt_pixels__valid,
  input  logic [PIXELS_PER_CHAR-1:0] tt_pixels__red,
  input  logic [PIXELS_PER_CHAR-1:0] tt_pixels__green,
  input  logic [PIXELS_PER_CHAR-1:0] tt_pixels__blue,
  output logic [PPT-1:0]             red,
  output logic [PPT-1:0]             green,
  output logic [PPT-1:0]             blue,
  output logic                       pixels_valid,
  output logic [SW-1:0]              scanline,
  output logic [RW-1:0]              row,
  output logic                       flash
);
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  logic last_glr, last_dew, glr_fall, dew_rise, last_line;
  logic [FW-1:0] flash_count;
  logic [PPT-1:0] red_s, green_s, blue_s;
  logic pv_s;
  assign tt_character__valid = lose & char_enable;
  assign tt_character__character = data_in;
  assign tt_timings__smoothe = 1'b1;
  assign tt_timings__first_scanline_of_row = scanline == '0;
  assign glr_fall = last_glr & ~glr;
  assign dew_rise = dew & ~last_dew;
  assign last_line = scanline == SW'(SCANLINES_PER_ROW - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_glr <= 1'b0;
      last_dew <= 1'b0;
      tt_timings__end_of_scanline <= 1'b0;
      tt_timings__restart_frame <= 1'b0;
      tt_timings__interpolate_vertical <= 2'd0;
      scanline <= '0;
      row <= '0;
      flash_count <= '0;
      flash <= 1'b0;
    end else begin
      last_glr <= glr;
      last_dew <= dew;
      if (glr_fall) tt_timings__end_of_scanline <= 1'b1;
      else if (char_enable) tt_timings__end_of_scanline <= 1'b0;
      if (dew) begin
        tt_timings__restart_frame <= 1'b1;
        tt_timings__interpolate_vertical <= crs ? 2'd2 : 2'd1;
        scanline <= '0;
        row <= '0;
      end else begin
        if (char_enable) tt_timings__restart_frame <= 1'b0;
        if (glr_fall) begin
          scanline <= last_line ? '0 : scanline + 1'b1;
          if (last_line && row != RW'(ROWS_PER_FRAME - 1)) row <= row + 1'b1;
        end
      end
      if (dew_rise) begin
        flash_count <= flash_count == FW'(FLASH_FRAMES - 1) ? '0 : flash_count + 1'b1;
        if (flash_count == FW'(FLASH_FRAMES - 1)) flash <= ~flash;
      end
    end
  end
  if (TICKS_PER_CHAR == 1) begin : g_pass
    assign red_s = tt_pixels__red;
    assign green_s = tt_pixels__green;
    assign blue_s = tt_pixels__blue;
    assign pv_s = tt_pixels__valid;
  end else begin : g_ser
    localparam int IW = $clog2(TICKS_PER_CHAR);
    logic [IW-1:0] idx;
    logic [PIXELS_PER_CHAR-1:0] sr, sg, sb;
    logic busy;
    assign busy = idx != '0;
    // the stored word is pre-shifted so its next slice always sits at the top
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        idx <= '0;
        sr <= '0;
        sg <= '0;
        sb <= '0;
      end else if (tt_pixels__valid) begin
        idx <= IW'(1);
        sr <= tt_pixels__red << PPT;
        sg <= tt_pixels__green << PPT;
        sb <= tt_pixels__blue << PPT;
      end else if (busy) begin
        idx <= idx == IW'(TICKS_PER_CHAR - 1) ? '0 : idx + 1'b1;
        sr <= sr << PPT;
        sg <= sg << PPT;
        sb <= sb << PPT;
      end
    end
    assign red_s = tt_pixels__valid ? tt_pixels__red[PIXELS_PER_CHAR-1 -: PPT] : busy ? sr[PIXELS_PER_CHAR-1 -: PPT] : '0;
    assign green_s = tt_pixels__valid ? tt_pixels__green[PIXELS_PER_CHAR-1 -: PPT] : busy ? sg[PIXELS_PER_CHAR-1 -: PPT] : '0;
    assign blue_s = tt_pixels__valid ? tt_pixels__blue[PIXELS_PER_CHAR-1 -: PPT] : busy ? sb[PIXELS_PER_CHAR-1 -: PPT] : '0;
    assign pv_s = tt_pixels__valid | busy;
  end
`ifdef TELETEXT_FRONTEND_PO_BLANK_EN
  logic po_q;
  always_ff @(posedge clk) begin
    if (!reset_n) po_q <= 1'b0;
    else if (char_enable) po_q <= po;
  end
  assign blan = ~po_q;
  assign red = po_q ? red_s : '0;
  assign green = po_q ? green_s : '0;
  assign blue = po_q ? blue_s : '0;
  assign pixels_valid = pv_s & po_q;
`else
  assign red = red_s;
  assign green = green_s;
  assign blue = blue_s;
  assign pixels_valid = pv_s;
`endif
endmodule

// File: tb/tb_teletext_frontend.sv
// tb_teletext_frontend: checks teletext_frontend (T=2 and T=3) against a counting/queue model plus literal pins.
module tb_teletext_frontend;
  logic clk = 0, reset_n = 0, ce = 0, lose = 0, glr = 0, dew = 0, crs = 0, pv = 0;
  logic [6:0] data_in = 0;
  logic [11:0] pr = 0, pg = 0, pb = 0;
  logic cv, rf, eos, fsr, sm, pv2, fl;
  logic [6:0] cc;
  logic [1:0] iv;
  logic [5:0] r2, g2, b2;
  logic [3:0] sl, r3, g3, b3;
  logic [4:0] rw;
  logic pv3, cv3, rf3, eos3, fsr3, sm3, fl3;
  logic [6:0] cc3;
  logic [1:0] iv3;
  logic [3:0] sl3;
  logic [4:0] rw3;
  int passes = 0, total = 0;
  bit armed = 0;
  int m_line, m_rises, m_iv;
  bit m_eos, m_rf, mlg, mld;
  int q2[$], q3[$];

  always #5 clk = ~clk;

  teletext_frontend dut (
    .clk(clk), .reset_n(reset_n), .char_enable(ce), .lose(lose), .glr(glr), .dew(dew), .crs(crs),
    .data_in(data_in), .tt_character__valid(cv), .tt_character__character(cc),
    .tt_timings__restart_frame(rf), .tt_timings__end_of_scanline(eos),
    .tt_timings__first_scanline_of_row(fsr), .tt_timings__smoothe(sm),
    .tt_timings__interpolate_vertical(iv), .tt_pixels__valid(pv), .tt_pixels__red(pr),
    .tt_pixels__green(pg), .tt_pixels__blue(pb), .red(r2), .green(g2), .blue(b2),
    .pixels_valid(pv2), .scanline(sl), .row(rw), .flash(fl));

  teletext_frontend #(.TICKS_PER_CHAR(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .char_enable(ce), .lose(lose), .glr(glr), .dew(dew), .crs(crs),
    .data_in(data_in), .tt_character__valid(cv3), .tt_character__character(cc3),
    .tt_timings__restart_frame(rf3), .tt_timings__end_of_scanline(eos3),
    .tt_timings__first_scanline_of_row(fsr3), .tt_timings__smoothe(sm3),
    .tt_timings__interpolate_vertical(iv3), .tt_pixels__valid(pv), .tt_pixels__red(pr),
    .tt_pixels__green(pg), .tt_pixels__blue(pb), .red(r3), .green(g3), .blue(b3),
    .pixels_valid(pv3), .scanline(sl3), .row(rw3), .flash(fl3));

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  function automatic int sli(int w, int k, int ppt);
    return (w >> (12 - (k + 1) * ppt)) & ((1 << ppt) - 1);
  endfunction

  function automatic int pk(int k, int ppt);
    return (sli(pr, k, ppt) << (2 * ppt)) | (sli(pg, k, ppt) << ppt) | sli(pb, k, ppt);
  endfunction

  // model: scanline/row derived from the number of glr falls since the last dew
  always @(posedge clk) begin
    if (!reset_n) begin
      armed = 1; m_line = 0; m_rises = 0; m_iv = 0; m_eos = 0; m_rf = 0; mlg = 0; mld = 0;
      q2.delete(); q3.delete();
    end else begin
      if (dew) begin
        m_line = 0; m_rf = 1; m_iv = crs ? 2 : 1;
      end else begin
        if (ce) m_rf = 0;
        if (mlg && !glr) m_line++;
      end
      if (mlg && !glr) m_eos = 1;
      else if (ce) m_eos = 0;
      if (dew && !mld) m_rises++;
      if (pv) begin
        q2.delete(); q3.delete();
        q2.push_back(pk(1, 6));
        q3.push_back(pk(1, 4)); q3.push_back(pk(2, 4));
      end else begin
        if (q2.size() != 0) void'(q2.pop_front());
        if (q3.size() != 0) void'(q3.pop_front());
      end
      mlg = glr; mld = dew;
    end
  end

  always @(negedge clk) begin
    if (armed && reset_n) begin
      chk("char_valid", int'(cv), int'(lose & ce));
      chk("character", int'(cc), int'(data_in));
      chk("restart_frame", int'(rf), int'(m_rf));
      chk("end_of_scanline", int'(eos), int'(m_eos));
      chk("first_scanline", int'(fsr), int'((m_line % 10) == 0));
      chk("smoothe", int'(sm), 1);
      chk("interp_vert", int'(iv), m_iv);
      chk("scanline", int'(sl), m_line % 10);
      chk("row", int'(rw), (m_line / 10) > 24 ? 24 : m_line / 10);
      chk("flash", int'(fl), (m_rises / 16) % 2);
      chk("pix_t2", int'({r2, g2, b2}), pv ? pk(0, 6) : (q2.size() != 0 ? q2[0] : 0));
      chk("pv_t2", int'(pv2), int'(pv || q2.size() != 0));
      chk("pix_t3", int'({r3, g3, b3}), pv ? pk(0, 4) : (q3.size() != 0 ? q3[0] : 0));
      chk("pv_t3", int'(pv3), int'(pv || q3.size() != 0));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    ce = ~ce;
    data_in = data_in + 7'd1;
    lose = data_in[1];
  endtask

  task automatic glr_edge();
    glr = 1; tick();
    glr = 0; tick();
  endtask

  initial begin
    repeat (3) tick();
    reset_n = 1;
    tick();
    @(negedge clk);
    chk("rst_scanline", int'(sl), 0);
    chk("rst_iv", int'(iv), 0);
    chk("rst_smoothe", int'(sm), 1);
    chk("rst_pv", int'(pv2), 0);
    chk("rst_red", int'(r2), 0);
    dew = 1; crs = 1; tick();
    @(negedge clk);
    chk("lit_restart", int'(rf), 1);
    dew = 0; crs = 0; tick();
    repeat (3) glr_edge();
    @(negedge clk);
    chk("lit_scan3", int'(sl), 3);
    chk("lit_row0", int'(rw), 0);
    chk("lit_iv2", int'(iv), 2);
    dew = 1; tick();
    dew = 0; tick();
    repeat (10) glr_edge();
    @(negedge clk);
    chk("lit_scan10", int'(sl), 0);
    chk("lit_row1", int'(rw), 1);
    chk("lit_iv1", int'(iv), 1);
    repeat (240) glr_edge();
    @(negedge clk);
    chk("lit_row24", int'(rw), 24);
    repeat (15) glr_edge();
    @(negedge clk);
    chk("lit_row_sat", int'(rw), 24);
    chk("lit_scan5", int'(sl), 5);
    pv = 1; pr = 12'hA5C; pg = 12'h3C3; pb = 12'hF0F;
    @(negedge clk);
    chk("lit_red_s0", int'(r2), 'h29);
    chk("lit_red3_s0", int'(r3), 'hA);
    tick();
    pv = 0;
    @(negedge clk);
    chk("lit_red_s1", int'(r2), 'h1C);
    chk("lit_pv_s1", int'(pv2), 1);
    chk("lit_red3_s1", int'(r3), 'h5);
    tick();
    @(negedge clk);
    chk("lit_pv_idle", int'(pv2), 0);
    chk("lit_red3_s2", int'(r3), 'hC);
    tick();
    @(negedge clk);
    chk("lit_pv3_idle", int'(pv3), 0);
    pv = 1; pr = 12'h123; pg = 12'h456; pb = 12'h789;
    tick();
    pr = 12'hABC; pg = 12'hDEF; pb = 12'h024;
    @(negedge clk);
    chk("lit_abort_s0", int'(r3), 'hA);
    tick();
    pv = 0;
    @(negedge clk);
    chk("lit_abort_s1", int'(r3), 'hB);
    repeat (3) tick();
    reset_n = 0; tick(); tick();
    reset_n = 1; tick();
    repeat (15) begin dew = 1; tick(); dew = 0; tick(); end
    @(negedge clk);
    chk("lit_flash15", int'(fl), 0);
    dew = 1; tick(); dew = 0; tick();
    @(negedge clk);
    chk("lit_flash16", int'(fl), 1);
    repeat (2) glr_edge();
    glr = 1; tick();
    glr = 0; dew = 1; tick();
    @(negedge clk);
    chk("lit_both_scan", int'(sl), 0);
    chk("lit_both_eos", int'(eos), 1);
    dew = 0;
    repeat (4) tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
